// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter.
//   NREQ_MAX           - largest supported requester count
//   RD_LATENCY_DEFAULT - default RAM read latency in cycles
//   req_idx_t          - requester index
//   rd_track_t         - one read-tracking entry {valid, owner}
package dmem_arb_pkg;

  localparam int NREQ_MAX = 4;
  localparam int RD_LATENCY_DEFAULT = 1;

  typedef logic [1:0] req_idx_t;

  typedef struct packed {
    logic     valid;
    req_idx_t owner;
  } rd_track_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with lock override.
// Ports:
//   i_req        - per-requester request
//   i_lastGnt    - index granted most recently; search starts one past it
//   i_lockEn     - lock is in force this cycle (owner still requesting)
//   i_lockOwner  - requester holding the lock
//   o_gnt        - one-hot grant
//   o_gntValid   - some requester was granted
//   o_gntIdx     - index of the granted requester
module rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  req_idx_t        i_lastGnt,
  input  logic            i_lockEn,
  input  req_idx_t        i_lockOwner,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_gntValid,
  output req_idx_t        o_gntIdx
);

  logic [NREQ_MAX-1:0] w_reqPad;
  logic [NREQ_MAX-1:0] w_gntPad;
  logic                w_found;
  req_idx_t            w_cand;

  // Requests are padded to NREQ_MAX so a 2-bit index is always in range.
  // With the lock in force only the owner may win; otherwise the first
  // requester found walking from lastGnt+1 (wrapping) wins.
  always_comb begin
    w_reqPad   = NREQ_MAX'(i_req);
    w_gntPad   = '0;
    w_found    = 1'b0;
    w_cand     = '0;
    o_gntValid = 1'b0;
    o_gntIdx   = '0;
    if (i_lockEn) begin
      w_gntPad[i_lockOwner] = w_reqPad[i_lockOwner];
      o_gntValid            = w_reqPad[i_lockOwner];
      o_gntIdx              = i_lockOwner;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        w_cand = req_idx_t'((int'(i_lastGnt) + k) % NREQ);
        if (!w_found && w_reqPad[w_cand]) begin
          w_found          = 1'b1;
          w_gntPad[w_cand] = 1'b1;
          o_gntValid       = 1'b1;
          o_gntIdx         = w_cand;
        end
      end
    end
    o_gnt = w_gntPad[NREQ-1:0];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous data-RAM port between NREQ requesters
// (0 = core LSU, 1 = debug/DMA). Zero-latency round-robin grant, optional
// bus lock for read-modify-write, and read tracking so returning RAM data
// is flagged to the requester that issued the read.
// Ports:
//   clk, rstn                 - clock, synchronous active-low reset
//   i_m_req/we/lock           - per-requester request, write, lock
//   i_m_addr/wdata/be         - packed per-requester address, data, byte enables
//   o_m_gnt                   - one-hot grant, same cycle as request
//   o_m_rvalid, o_m_rdata     - one-hot read-data valid and shared read data
//   o_ram_req/we/addr/wdata/be- RAM access driven from the granted requester
//   i_ram_rdata               - RAM read data, RD_LATENCY after a read strobe
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int RD_LATENCY = RD_LATENCY_DEFAULT,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    i_m_req,
  input  logic [NREQ-1:0]    i_m_we,
  input  logic [NREQ-1:0]    i_m_lock,
  input  logic [NREQ*AW-1:0] i_m_addr,
  input  logic [NREQ*DW-1:0] i_m_wdata,
  input  logic [NREQ*4-1:0]  i_m_be,
  output logic [NREQ-1:0]    o_m_gnt,
  output logic [NREQ-1:0]    o_m_rvalid,
  output logic [DW-1:0]      o_m_rdata,
  output logic               o_ram_req,
  output logic               o_ram_we,
  output logic [AW-1:0]      o_ram_addr,
  output logic [DW-1:0]      o_ram_wdata,
  output logic [3:0]         o_ram_be,
  input  logic [DW-1:0]      i_ram_rdata
);

  req_idx_t                   r_lastGnt;
  req_idx_t                   r_lockOwner;
  logic                       r_locked;
  rd_track_t [RD_LATENCY-1:0] r_track;

  logic [NREQ-1:0]     w_req;
  logic [NREQ_MAX-1:0] w_reqPad;
  logic [NREQ_MAX-1:0] w_lockPad;
  logic [NREQ_MAX-1:0] w_wePad;
  logic                w_lockEn;
  logic [NREQ-1:0]     w_gnt;
  logic                w_gntValid;
  req_idx_t            w_gntIdx;
  rd_track_t           w_tail;
  logic [NREQ_MAX-1:0] w_rvPad;

  // Requests are masked during reset so every output reads zero.
  assign w_req     = rstn ? i_m_req : '0;
  assign w_reqPad  = NREQ_MAX'(w_req);
  assign w_lockPad = NREQ_MAX'(i_m_lock);
  assign w_wePad   = NREQ_MAX'(i_m_we);

  // The lock only holds while its owner keeps both req and lock high; the
  // cycle it drops either, arbitration is already plain round-robin.
  assign w_lockEn = (NREQ > 1) && r_locked &&
                    w_reqPad[r_lockOwner] && w_lockPad[r_lockOwner];

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req       (w_req),
    .i_lastGnt   (r_lastGnt),
    .i_lockEn    (w_lockEn),
    .i_lockOwner (r_lockOwner),
    .o_gnt       (w_gnt),
    .o_gntValid  (w_gntValid),
    .o_gntIdx    (w_gntIdx)
  );

  assign o_m_gnt   = w_gnt;
  assign o_ram_req = w_gntValid;

  // RAM fields come from the granted requester and are zero without a grant.
  always_comb begin
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    o_ram_be    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        o_ram_we    = i_m_we[i];
        o_ram_addr  = i_m_addr[i*AW +: AW];
        o_ram_wdata = i_m_wdata[i*DW +: DW];
        o_ram_be    = i_m_be[i*4 +: 4];
      end
    end
  end

  // Grant history, lock ownership and the read-tracking shift register.
  // Entry 0 records each granted read; the tail lines up with ram_rdata.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lastGnt   <= req_idx_t'(NREQ - 1);
      r_lockOwner <= '0;
      r_locked    <= 1'b0;
      r_track     <= '0;
    end else begin
      if (w_gntValid) begin
        r_lastGnt   <= w_gntIdx;
        r_lockOwner <= w_gntIdx;
        r_locked    <= (NREQ > 1) && w_lockPad[w_gntIdx];
      end else begin
        r_locked <= 1'b0;
      end
      r_track[0] <= '{valid: w_gntValid & ~w_wePad[w_gntIdx], owner: w_gntIdx};
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_track[i] <= r_track[i-1];
      end
    end
  end

  assign w_tail = r_track[RD_LATENCY-1];

  // Read response steering; gated by rstn so nothing escapes during reset.
  always_comb begin
    w_rvPad   = '0;
    o_m_rdata = '0;
    if (rstn && w_tail.valid) begin
      w_rvPad[w_tail.owner] = 1'b1;
      o_m_rdata             = i_ram_rdata;
    end
    o_m_rvalid = w_rvPad[NREQ-1:0];
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios followed by random
// traffic, checked against a behavioural model of grants, lock and memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int RDL = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RANDOM_CYCLES = 600;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] gnt;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [3:0]      be;
  } gntExp_t;

  typedef struct {
    int            due;
    int            owner;
    logic [DW-1:0] data;
  } rdExp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NREQ-1:0] mReq = '0, mWe = '0, mLock = '0;
  logic [NREQ*AW-1:0] mAddr = '0;
  logic [NREQ*DW-1:0] mWdata = '0;
  logic [NREQ*4-1:0] mBe = '0;
  logic [NREQ-1:0] mGnt, mRvalid;
  logic [DW-1:0] mRdata;
  logic ramReq, ramWe;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramWdata, ramRdata;
  logic [3:0] ramBe;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  gntExp_t gntQ[$];
  rdExp_t rdQ[$];

  bit sReq[NREQ], sWe[NREQ], sLock[NREQ];
  logic [AW-1:0] sAddr[NREQ];
  logic [DW-1:0] sWdata[NREQ];
  logic [3:0] sBe[NREQ];

  int refLast;
  bit refLocked;
  int refOwner;
  logic [DW-1:0] refMem[16];
  int lastGrantIdx;

  logic [DW-1:0] envMem[16];
  logic [DW-1:0] envPipe[RDL];

  always #5 clk = ~clk;

  dmem_arbiter #(.NREQ(NREQ), .RD_LATENCY(RDL), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_m_req     (mReq),
    .i_m_we      (mWe),
    .i_m_lock    (mLock),
    .i_m_addr    (mAddr),
    .i_m_wdata   (mWdata),
    .i_m_be      (mBe),
    .o_m_gnt     (mGnt),
    .o_m_rvalid  (mRvalid),
    .o_m_rdata   (mRdata),
    .o_ram_req   (ramReq),
    .o_ram_we    (ramWe),
    .o_ram_addr  (ramAddr),
    .o_ram_wdata (ramWdata),
    .o_ram_be    (ramBe),
    .i_ram_rdata (ramRdata)
  );

  function automatic logic [DW-1:0] memInit(input int a);
    return 32'h1357_0000 + 32'(a) * 32'h0011_0101;
  endfunction

  // Synchronous RAM seen by the arbiter: 16 words, RDL-cycle read pipe.
  assign ramRdata = envPipe[RDL-1];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int a = 0; a < 16; a++) envMem[a] <= memInit(a);
    end else if (ramReq && ramWe) begin
      for (int b = 0; b < 4; b++)
        if (ramBe[b]) envMem[ramAddr[3:0]][b*8 +: 8] <= ramWdata[b*8 +: 8];
    end
    if (ramReq && !ramWe) envPipe[0] <= envMem[ramAddr[3:0]];
    else envPipe[0] <= $urandom;
    for (int i = 1; i < RDL; i++) envPipe[i] <= envPipe[i-1];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, expv);
    end
  endtask

  task automatic setReq(input int i, input bit req, input bit we, input bit lock,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [3:0] be);
    sReq[i] = req; sWe[i] = we; sLock[i] = lock;
    sAddr[i] = addr; sWdata[i] = wdata; sBe[i] = be;
  endtask

  task automatic idleAll();
    for (int i = 0; i < NREQ; i++) setReq(i, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic newTxn(input int i);
    if ($urandom_range(0, 3) != 0)
      setReq(i, 1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
             AW'($urandom_range(0, 15)), $urandom, 4'($urandom_range(1, 15)));
    else
      setReq(i, 0, 0, 0, '0, '0, '0);
  endtask

  // Drive one cycle of stimulus, predict the grant, RAM drive and any read
  // response from the arbitration rules, and queue those expectations.
  task automatic applyStimulus(input bit rstnVal);
    gntExp_t e;
    int g;
    int idx;
    rstn = rstnVal;
    for (int i = 0; i < NREQ; i++) begin
      mReq[i] = sReq[i]; mWe[i] = sWe[i]; mLock[i] = sLock[i];
      mAddr[i*AW +: AW] = sAddr[i];
      mWdata[i*DW +: DW] = sWdata[i];
      mBe[i*4 +: 4] = sBe[i];
    end
    g = -1;
    if (!rstnVal) begin
      refLast = NREQ - 1; refLocked = 0; refOwner = 0;
      rdQ.delete();
      for (int a = 0; a < 16; a++) refMem[a] = memInit(a);
    end else begin
      if (refLocked && sReq[refOwner] && sLock[refOwner]) g = refOwner;
      else
        for (int k = 1; k <= NREQ; k++)
          if (g < 0 && sReq[(refLast + k) % NREQ]) g = (refLast + k) % NREQ;
      if (g >= 0) begin
        refLast = g; refOwner = g; refLocked = (NREQ > 1) && sLock[g];
      end else begin
        refLocked = 0;
      end
    end
    e.cyc = cyc; e.gnt = '0; e.we = 0; e.addr = '0; e.wdata = '0; e.be = '0;
    if (g >= 0) begin
      e.gnt[g] = 1'b1; e.we = sWe[g]; e.addr = sAddr[g];
      e.wdata = sWdata[g]; e.be = sBe[g];
      idx = int'(sAddr[g][3:0]);
      if (sWe[g]) begin
        for (int b = 0; b < 4; b++)
          if (sBe[g][b]) refMem[idx][b*8 +: 8] = sWdata[g][b*8 +: 8];
      end else begin
        rdQ.push_back('{due: cyc + RDL, owner: g, data: refMem[idx]});
      end
    end
    gntQ.push_back(e);
    lastGrantIdx = g;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: on every falling edge compare the DUT against the expectation
  // queued for this cycle, and against any read response now due.
  always @(negedge clk) begin
    gntExp_t e;
    rdExp_t r;
    logic [NREQ-1:0] expRv;
    logic [DW-1:0] expRd;
    if (gntQ.size() > 0) begin
      e = gntQ.pop_front();
      checkOutput("gnt", 64'(mGnt), 64'(e.gnt));
      checkOutput("ram_req", 64'(ramReq), 64'(e.gnt != '0));
      checkOutput("ram_we", 64'(ramWe), 64'(e.we));
      checkOutput("ram_addr", 64'(ramAddr), 64'(e.addr));
      checkOutput("ram_wdata", 64'(ramWdata), 64'(e.wdata));
      checkOutput("ram_be", 64'(ramBe), 64'(e.be));
      expRv = '0;
      expRd = '0;
      if (rdQ.size() > 0 && rdQ[0].due <= e.cyc) begin
        r = rdQ.pop_front();
        checkOutput("rd_due", 64'(r.due), 64'(e.cyc));
        expRv[r.owner] = 1'b1;
        expRd = r.data;
      end
      checkOutput("rvalid", 64'(mRvalid), 64'(expRv));
      checkOutput("rdata", 64'(mRdata), 64'(expRd));
    end
  end

  initial begin
    idleAll();
    @(posedge clk);
    #1;
    applyStimulus(0);
    applyStimulus(0);

    // Single read from the LSU
    setReq(0, 1, 0, 0, 32'h100, '0, 4'hF);
    applyStimulus(1);
    idleAll();
    repeat (RDL + 1) applyStimulus(1);

    // Both requesting after reset: alternate starting with requester 0
    applyStimulus(0);
    setReq(0, 1, 0, 0, 32'h8, '0, 4'hF);
    setReq(1, 1, 0, 0, 32'hC, '0, 4'hF);
    repeat (4) applyStimulus(1);
    idleAll();
    repeat (RDL + 1) applyStimulus(1);

    // Requester 1 locks for three cycles, then releases to requester 0
    applyStimulus(0);
    setReq(0, 1, 0, 0, 32'h1, '0, 4'hF);
    applyStimulus(1);
    setReq(0, 1, 0, 0, 32'h2, '0, 4'hF);
    setReq(1, 1, 1, 1, 32'h3, 32'h55AA_55AA, 4'hF);
    repeat (3) applyStimulus(1);
    setReq(1, 1, 1, 0, 32'h3, 32'h55AA_55AA, 4'hF);
    applyStimulus(1);
    idleAll();
    repeat (RDL + 1) applyStimulus(1);

    // Back-to-back reads from different requesters
    setReq(0, 1, 0, 0, 32'h10, '0, 4'hF);
    applyStimulus(1);
    idleAll();
    setReq(1, 1, 0, 0, 32'h20, '0, 4'hF);
    applyStimulus(1);
    idleAll();
    repeat (RDL + 1) applyStimulus(1);

    // Partial write, then read back the merged word
    setReq(1, 1, 1, 0, 32'h44, 32'h0000_ABCD, 4'b0011);
    applyStimulus(1);
    idleAll();
    setReq(0, 1, 0, 0, 32'h44, '0, 4'hF);
    applyStimulus(1);
    idleAll();
    repeat (RDL + 1) applyStimulus(1);

    // Reset right after a read is granted drops the response
    setReq(0, 1, 0, 0, 32'h5, '0, 4'hF);
    applyStimulus(1);
    idleAll();
    applyStimulus(0);
    setReq(0, 1, 0, 0, 32'h6, '0, 4'hF);
    setReq(1, 1, 0, 0, 32'h7, '0, 4'hF);
    applyStimulus(1);
    idleAll();
    repeat (RDL + 1) applyStimulus(1);

    // Random traffic with occasional resets
    for (int i = 0; i < NREQ; i++) newTxn(i);
    for (int n = 0; n < RANDOM_CYCLES; n++) begin
      applyStimulus($urandom_range(0, 149) != 0);
      for (int i = 0; i < NREQ; i++)
        if (i == lastGrantIdx || (!sReq[i] && $urandom_range(0, 1) == 1)) newTxn(i);
    end
    idleAll();
    repeat (RDL + 2) applyStimulus(1);

    checkOutput("drain_rdq", 64'(rdQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
